// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: parametrised AXI4-Lite slave register file.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   aw*/w*/b*            : write address / data / response channels; AW and W
//                          are accepted independently and held until both exist
//   ar*/r*               : read address / data channels
//   reg_out              : flattened RW register contents (RO slots drive 0)
//   hw_in                : status values returned for read-only registers
// RO_MASK bit i = 1 makes register i read-only (reads return hw_in slice i,
// writes answer SLVERR). Out-of-range word indices answer SLVERR.
module axi_lite_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         awvalid,
  input  logic [ADDR_W-1:0]            awaddr,
  output logic                         awready,
  input  logic                         wvalid,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  output logic                         wready,
  output logic                         bvalid,
  output logic [1:0]                   bresp,
  input  logic                         bready,
  input  logic                         arvalid,
  input  logic [ADDR_W-1:0]            araddr,
  output logic                         arready,
  output logic                         rvalid,
  output logic [DATA_W-1:0]            rdata,
  output logic [1:0]                   rresp,
  input  logic                         rready,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_in
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // init_q keeps every ready low during reset and lets them rise one cycle later
  logic                       init_q;
  logic                       aw_held_q, aw_held_d;
  logic [ADDR_W-1:0]          aw_addr_q, aw_addr_d;
  logic                       w_held_q, w_held_d;
  logic [DATA_W-1:0]          w_data_q, w_data_d;
  logic [STRB_W-1:0]          w_strb_q, w_strb_d;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic                       bvalid_q, bvalid_d;
  logic [1:0]                 bresp_q, bresp_d;
  logic                       rvalid_q, rvalid_d;
  logic [1:0]                 rresp_q, rresp_d;
  logic [DATA_W-1:0]          rdata_q, rdata_d;

  logic                       aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_W-1:0]          w_addr_eff, w_idx, r_idx;
  logic [DATA_W-1:0]          w_data_eff;
  logic [STRB_W-1:0]          w_strb_eff;

  // Readies depend on flops only: no path from valid/ready inputs.
  assign awready = init_q && !aw_held_q && !bvalid_q;
  assign wready  = init_q && !w_held_q && !bvalid_q;
  assign arready = init_q && !rvalid_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

  always_comb begin
    aw_hs      = awvalid && awready;
    w_hs       = wvalid && wready;
    ar_hs      = arvalid && arready;
    // Address/data come from the holding register or the live handshake.
    w_addr_eff = aw_held_q ? aw_addr_q : awaddr;
    w_data_eff = w_held_q ? w_data_q : wdata;
    w_strb_eff = w_held_q ? w_strb_q : wstrb;
    commit     = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
    w_idx      = w_addr_eff >> OFF_W;
    r_idx      = araddr >> OFF_W;
  end

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    regs_d    = regs_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end
    if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
      bresp_d  = RESP_OKAY;
    end
    // Commit overrides the hold set above when the last piece arrives live.
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_SLVERR;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (w_idx == ADDR_W'(i) && !RO_MASK[i]) begin
          bresp_d = RESP_OKAY;
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (w_strb_eff[b])
              regs_d[i*DATA_W + 8*b +: 8] = w_data_eff[8*b +: 8];
          end
        end
      end
    end
  end

  // Reads sample regs_q, so a same-edge write is seen only by later reads.
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_SLVERR;
      rdata_d  = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (r_idx == ADDR_W'(i)) begin
          rresp_d = RESP_OKAY;
          rdata_d = RO_MASK[i] ? hw_in[i*DATA_W +: DATA_W] : regs_q[i*DATA_W +: DATA_W];
        end
      end
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
      rresp_d  = RESP_OKAY;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i])
        reg_out[i*DATA_W +: DATA_W] = regs_q[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q    <= 1'b0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      regs_q    <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      init_q    <= 1'b1;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      regs_q    <= regs_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile (8 x 32-bit, register 2 read-only).
module tb_axi_lite_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]        awaddr, araddr, wdata;
  logic [3:0]         wstrb;
  logic               awready, wready, bvalid, arready, rvalid;
  logic [1:0]         bresp, rresp;
  logic [31:0]        rdata;
  logic [NR*DW-1:0]   reg_out, hw_in;

  int checks   = 0;
  int failures = 0;

  axi_lite_regfile #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .NUM_REGS(8),
    .RO_MASK (8'h04)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .reg_out(reg_out), .hw_in(hw_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] slot(input int unsigned i);
    return reg_out[i*DW +: DW];
  endfunction

  // Called at a negedge; returns at a negedge after the response is seen.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit aw_done, w_done;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(negedge clk);
      n++;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_handshake", 32'(aw_done && w_done), 32'd1);
    chk("wr_bvalid_latency", 32'(bvalid), 32'd1);
    resp = bresp;
    if (bready) begin
      @(negedge clk);
      chk("wr_bvalid_clear", 32'(bvalid), 32'd0);
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    int n;
    n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_arready", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("rd_rvalid_latency", 32'(rvalid), 32'd1);
    d = rdata;
    resp = rresp;
    if (rready) begin
      @(negedge clk);
      chk("rd_rvalid_clear", 32'(rvalid), 32'd0);
    end
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;

    vecs[0]  = '{"w0_full",     1'b1, 32'h00, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{"r0_full",     1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{"w0_strb3",    1'b1, 32'h00, 32'h00005678, 4'h3, 2'b00, 32'h0};
    vecs[3]  = '{"r0_strb3",    1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'hDEAD5678};
    vecs[4]  = '{"w_oor",       1'b1, 32'h20, 32'h11111111, 4'hF, 2'b10, 32'h0};
    vecs[5]  = '{"r_oor",       1'b0, 32'h20, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[6]  = '{"w_ro",        1'b1, 32'h08, 32'h00000001, 4'hF, 2'b10, 32'h0};
    vecs[7]  = '{"r_ro",        1'b0, 32'h08, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
    vecs[8]  = '{"w3_strb0",    1'b1, 32'h0C, 32'hAABBCCDD, 4'h0, 2'b00, 32'h0};
    vecs[9]  = '{"r3_strb0",    1'b0, 32'h0C, 32'h0,        4'h0, 2'b00, 32'h0};
    vecs[10] = '{"w7_offset",   1'b1, 32'h1F, 32'hFFFFFFFF, 4'h5, 2'b00, 32'h0};
    vecs[11] = '{"r7_offset",   1'b0, 32'h1C, 32'h0,        4'h0, 2'b00, 32'h00FF00FF};
    vecs[12] = '{"w5_strbC",    1'b1, 32'h14, 32'hCAFEBABE, 4'hC, 2'b00, 32'h0};
    vecs[13] = '{"r5_strbC",    1'b0, 32'h15, 32'h0,        4'h0, 2'b00, 32'hCAFE0000};

    for (int i = 0; i < NR; i++) hw_in[i*DW +: DW] = 32'hB0D0_0000 | 32'(i);
    hw_in[2*DW +: DW] = 32'hCAFEF00D;

    rst_n = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;

    // Reset state and ready release
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready",  32'(wready),  32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_rdata",   rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", 32'(awready), 32'd1);
    chk("post_rst_wready",  32'(wready),  32'd1);
    chk("post_rst_arready", 32'(arready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        chk({vecs[i].name, "_bresp"}, 32'(resp), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, d, resp);
        chk({vecs[i].name, "_rdata"}, d, vecs[i].exp_rdata);
        chk({vecs[i].name, "_rresp"}, 32'(resp), 32'(vecs[i].exp_resp));
      end
    end
    chk("reg_out0", slot(0), 32'hDEAD5678);
    chk("reg_out2_ro_zero", slot(2), 32'h0);
    chk("reg_out7", slot(7), 32'h00FF00FF);

    // AW first, W three cycles later
    awaddr = 32'h4; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("aw_first_awready_low", 32'(awready), 32'd0);
    chk("aw_first_wready", 32'(wready), 32'd1);
    repeat (3) begin
      chk("aw_first_no_bvalid", 32'(bvalid), 32'd0);
      chk("aw_first_no_commit", slot(1), 32'h0);
      @(negedge clk);
    end
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("aw_first_bvalid", 32'(bvalid), 32'd1);
    chk("aw_first_bresp", 32'(bresp), 32'd0);
    chk("aw_first_reg1", slot(1), 32'h12345678);
    @(negedge clk);

    // W first, AW two cycles later
    wdata = 32'h0BADCAFE; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("w_first_wready_low", 32'(wready), 32'd0);
    repeat (2) @(negedge clk);
    chk("w_first_no_commit", slot(3), 32'h0);
    awaddr = 32'hC; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("w_first_bvalid", 32'(bvalid), 32'd1);
    chk("w_first_reg3", slot(3), 32'h0BADCAFE);
    @(negedge clk);

    // Read/write collision on the same edge returns the old value
    axi_write(32'h18, 32'h66666666, 4'hF, resp);
    awaddr = 32'h18; wdata = 32'h77777777; wstrb = 4'hF; araddr = 32'h18;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("coll_rvalid", 32'(rvalid), 32'd1);
    chk("coll_rdata_old", rdata, 32'h66666666);
    chk("coll_bvalid", 32'(bvalid), 32'd1);
    chk("coll_reg6_new", slot(6), 32'h77777777);
    @(negedge clk);

    // Back-pressured response, then reset with read pending
    bready = 1'b0;
    axi_write(32'h10, 32'h44444444, 4'hF, resp);
    repeat (5) begin
      @(negedge clk);
      chk("bp_bvalid", 32'(bvalid), 32'd1);
      chk("bp_bresp", 32'(bresp), 32'd0);
      chk("bp_awready", 32'(awready), 32'd0);
      chk("bp_wready", 32'(wready), 32'd0);
    end
    rready = 1'b0;
    axi_read(32'h10, d, resp);
    chk("bp_rdata", d, 32'h44444444);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bvalid", 32'(bvalid), 32'd0);
    chk("arst_rvalid", 32'(rvalid), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_awready", 32'(awready), 32'd0);
    chk("arst_arready", 32'(arready), 32'd0);
    chk("arst_reg4", slot(4), 32'd0);
    chk("arst_reg0", slot(0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bready = 1'b1; rready = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
Parametrised AXI4-Lite slave register file. It is the successor to the single-register axi_lite_slave. Adds:
- configurable register count and data width
- byte strobes and OKAY/SLVERR responses
- independent AW/W acceptance
- per-register read-only mapping to hardware status inputs

Sits between the AXI-Lite interconnect and peripheral control/status logic.

Parameters:
- DATA_W, 32: data bus width; multiple of 8.
- ADDR_W, 32: address bus width.
- NUM_REGS, 8: number of DATA_W-bit registers; >= 1.
- RO_MASK, 0: NUM_REGS-bit mask; bit i = 1 makes register i read-only, read from hw_in.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- awvalid  in  1  write address valid.
- awaddr  in  ADDR_W  write byte address.
- awready  out  1  write address ready.
- wvalid  in  1  write data valid.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte enables.
- wready  out  1  write data ready.
- bvalid  out  1  write response valid.
- bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- bready  in  1  write response ready.
- arvalid  in  1  read address valid.
- araddr  in  ADDR_W  read byte address.
- arready  out  1  read address ready.
- rvalid  out  1  read data valid.
- rdata  out  DATA_W  read data.
- rresp  out  2  read response: 00 OKAY, 10 SLVERR.
- rready  in  1  read data ready.
- reg_out  out  NUM_REGS*DATA_W  flattened RW register contents; register i at bits [i*DATA_W +: DATA_W]; RO slots drive 0.
- hw_in  in  NUM_REGS*DATA_W  status values returned for RO registers; same slicing.

Behaviour:
- Reset (rst_n low, asynchronous):
  - awready, wready, arready, bvalid, rvalid = 0; bresp, rresp = 00; rdata = 0.
  - All registers = 0; held AW/W cleared.
  - In-flight transactions are dropped with no response.
  - Ready outputs rise the first cycle after rst_n deasserts.
- Decode:
  - Word index = addr >> log2(DATA_W/8); low byte-offset bits are ignored.
  - Index >= NUM_REGS means out-of-range.
- AW channel:
  - awready = !aw_held && !bvalid.
  - Handshake (awvalid && awready) latches awaddr into aw_held.
- W channel:
  - wready = !w_held && !bvalid.
  - Handshake latches wdata and wstrb into w_held.
  - AW and W may arrive in either order, same cycle or any cycles apart.
- Write commit:
  - Occurs on the rising edge where both address and data are available, each either held or handshaking that edge, and bvalid is 0.
  - On that edge: for each byte b with wstrb[b] = 1, reg[idx][8b+:8] <= wdata[8b+:8]; bvalid <= 1; aw_held and w_held are cleared.
  - Latency: bvalid is high the cycle after the later of the two handshakes.
- Write errors: out-of-range, or RO_MASK[idx] = 1 → no register change; bresp = 10. Otherwise bresp = 00. wstrb = 0 → no change, bresp = 00.
- Write response: bvalid/bresp are held stable until bready; they clear on the edge where bvalid && bready. awready and wready are low while bvalid is high (one outstanding write).
- Read:
  - arready = !rvalid.
  - On the AR handshake edge: rdata <= register value (hw_in slice if RO); rvalid <= 1.
  - Out-of-range: rdata = 0, rresp = 10; otherwise rresp = 00.
  - rvalid, rdata and rresp are held stable until rready; they clear on the edge where rvalid && rready (rdata holds last value).
  - Latency: rvalid is high the cycle after the AR handshake.
- Read/write collision: if the AR handshake and a write commit to the same register share an edge, the read returns the pre-write value. The write still commits.
- Read and write paths are fully independent and may be active concurrently.
- No combinational path from any valid/ready input to any ready output.

Test Plan:
1. Simultaneous AW and W, addr 0x0, data 0xDEADBEEF, wstrb 0xF, bready = 1 → bvalid high 1 cycle later, bresp 00, reg_out[31:0] = 0xDEADBEEF. Read of 0x0 → rvalid 1 cycle after AR handshake, rdata 0xDEADBEEF, rresp 00.
2. AW to 0x4 first, W 0x12345678 three cycles later → awready low after the AW handshake and no commit until W. bvalid follows the W handshake by 1 cycle; reg 1 = 0x12345678.
3. Reg 0 = 0xDEADBEEF, write 0x00005678 to 0x0 with wstrb 0011 → reg 0 = 0xDEAD5678.
4. NUM_REGS = 8, write/read at 0x20 → bresp 10, no register change; rdata 0, rresp 10.
5. RO_MASK = 0x04, hw_in slot 2 = 0xCAFEF00D, write 0x1 to 0x8 → bresp 10; read 0x8 → 0xCAFEF00D.
6. bready held low 5 cycles → bvalid/bresp stable, awready and wready stay 0. Then rst_n pulsed low with rvalid pending → all outputs 0 immediately and registers 0.
